// File: rtl/amp_ph_averager.sv
// -----------------------------------------------------------------------------
// amp_ph_averager
//   Block averager for an amplitude/phase detector stream. Every block of
//   N = 2**LOG2_LEN valid samples yields the mean amplitude and the mean
//   per-sample phase increment, which is a frequency estimate. The first
//   valid sample after reset or clear only primes the previous-phase register.
//   Consecutive blocks share phase continuity, so there is no re-prime between
//   blocks.
//
// Parameters
//   DATA_WIDTH  unsigned amplitude width
//   PH_WIDTH    two's-complement phase width (wraps mod 2**PH_WIDTH)
//   LOG2_LEN    log2 of block length, legal 1..8
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous restart; returns to PRIME and drops any pending result
//   in_amp     amplitude sample
//   in_ph      phase sample
//   in_valid   sample qualifier
//   avg_amp    block mean amplitude (floor)
//   avg_dph    block mean phase increment (floor toward -inf)
//   avg_valid  one-cycle strobe, 1 clock after the Nth accepted sample
//   peak_amp   block maximum amplitude (only with AMP_PEAK_HOLD_EN)
//
// Build option
//   AMP_PEAK_HOLD_EN  adds the peak_amp output and its block-max tracker.
// -----------------------------------------------------------------------------
module amp_ph_averager #(
    parameter int DATA_WIDTH = 16,
    parameter int PH_WIDTH   = 16,
    parameter int LOG2_LEN   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_amp,
    input  logic [PH_WIDTH-1:0]   in_ph,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] avg_amp,
    output logic [PH_WIDTH-1:0]   avg_dph,
    output logic                  avg_valid
`ifdef AMP_PEAK_HOLD_EN
   ,output logic [DATA_WIDTH-1:0] peak_amp
`endif
);

    localparam int AW = DATA_WIDTH + LOG2_LEN;
    localparam int PW = PH_WIDTH + LOG2_LEN;
    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;
    localparam logic [LOG2_LEN-1:0] CNT_ONE  = LOG2_LEN'(1);

    typedef enum logic {PRIME, ACCUM} state_t;

    state_t                r_state, w_state_nxt;
    logic [LOG2_LEN-1:0]   r_cnt;
    logic [AW-1:0]         r_amp_sum;
    logic [PW-1:0]         r_dph_sum;
    logic [PH_WIDTH-1:0]   r_prev_ph;
    logic [DATA_WIDTH-1:0] r_avg_amp;
    logic [PH_WIDTH-1:0]   r_avg_dph;
    logic                  r_avg_valid;

    logic [PH_WIDTH-1:0]   w_dph;
    logic [AW-1:0]         w_amp_sum_nxt;
    logic [PW-1:0]         w_dph_sum_nxt;
    logic                  w_prime;
    logic                  w_accept;
    logic                  w_last;

    // Modular subtraction gives the wrapped increment directly; treating it
    // as signed and sign-extending makes a wrap across full scale look small.
    assign w_dph         = in_ph - r_prev_ph;
    assign w_dph_sum_nxt = r_dph_sum + {{LOG2_LEN{w_dph[PH_WIDTH-1]}}, w_dph};
    assign w_amp_sum_nxt = r_amp_sum + {{LOG2_LEN{1'b0}}, in_amp};

    assign w_prime  = in_valid && !clear && (r_state == PRIME);
    assign w_accept = in_valid && !clear && (r_state == ACCUM);
    assign w_last   = (r_cnt == CNT_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= PRIME;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear)        w_state_nxt = PRIME;
        else if (w_prime) w_state_nxt = ACCUM;
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_amp_sum   <= '0;
            r_dph_sum   <= '0;
            r_prev_ph   <= '0;
            r_avg_amp   <= '0;
            r_avg_dph   <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (clear) begin
                r_cnt     <= '0;
                r_amp_sum <= '0;
                r_dph_sum <= '0;
            end else if (w_prime) begin
                r_prev_ph <= in_ph;
                r_cnt     <= '0;
                r_amp_sum <= '0;
                r_dph_sum <= '0;
            end else if (w_accept) begin
                r_prev_ph <= in_ph;
                if (w_last) begin
                    // Dropping the low LOG2_LEN bits is the divide by N;
                    // for the two's-complement sum the kept slice equals
                    // an arithmetic shift, i.e. floor toward -inf.
                    r_avg_amp   <= w_amp_sum_nxt[AW-1:LOG2_LEN];
                    r_avg_dph   <= w_dph_sum_nxt[PW-1:LOG2_LEN];
                    r_avg_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_amp_sum   <= '0;
                    r_dph_sum   <= '0;
                end else begin
                    r_cnt     <= r_cnt + CNT_ONE;
                    r_amp_sum <= w_amp_sum_nxt;
                    r_dph_sum <= w_dph_sum_nxt;
                end
            end
        end
    end

    assign avg_amp   = r_avg_amp;
    assign avg_dph   = r_avg_dph;
    assign avg_valid = r_avg_valid;

`ifdef AMP_PEAK_HOLD_EN
    logic [DATA_WIDTH-1:0] r_blk_peak;
    logic [DATA_WIDTH-1:0] r_peak_amp;
    logic [DATA_WIDTH-1:0] w_peak_nxt;

    assign w_peak_nxt = (in_amp > r_blk_peak) ? in_amp : r_blk_peak;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blk_peak <= '0;
            r_peak_amp <= '0;
        end else if (clear) begin
            r_blk_peak <= '0;
            r_peak_amp <= '0;
        end else if (w_prime) begin
            r_blk_peak <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_peak_amp <= w_peak_nxt;
                r_blk_peak <= '0;
            end else begin
                r_blk_peak <= w_peak_nxt;
            end
        end
    end

    assign peak_amp = r_peak_amp;
`endif

endmodule

// File: tb/tb_amp_ph_averager.sv
// -----------------------------------------------------------------------------
// tb_amp_ph_averager
//   Self-checking bench for amp_ph_averager (N=4, 16-bit widths). A queue-based
//   reference model collects block samples and computes means with integer
//   arithmetic. Inputs change 1 time unit after the rising edge, and outputs
//   are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_amp_ph_averager;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in_amp = '0;
    logic [15:0] in_ph = '0;
    logic        in_valid = 1'b0;
    logic [15:0] avg_amp;
    logic [15:0] avg_dph;
    logic        avg_valid;
    logic [15:0] pk_obs;

    int n_checks = 0;
    int n_fail   = 0;

    amp_ph_averager #(.DATA_WIDTH(16), .PH_WIDTH(16), .LOG2_LEN(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_amp    (in_amp),
        .in_ph     (in_ph),
        .in_valid  (in_valid),
        .avg_amp   (avg_amp),
        .avg_dph   (avg_dph),
        .avg_valid (avg_valid)
`ifdef AMP_PEAK_HOLD_EN
       ,.peak_amp  (pk_obs)
`endif
    );

`ifndef AMP_PEAK_HOLD_EN
    assign pk_obs = '0;
`endif

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    bit          m_primed = 0;
    int          m_prev = 0;
    int          m_amps[$];
    int          m_dphs[$];
    logic [15:0] m_avg_amp = '0;
    logic [15:0] m_avg_dph = '0;
    logic [15:0] m_peak = '0;

    function automatic bit mdl_sample(int amp, int ph);
        int d, sa, sd, q, pk;
        if (!m_primed) begin
            m_primed = 1;
            m_prev = ph;
            m_amps.delete();
            m_dphs.delete();
            return 0;
        end
        d = (ph - m_prev) & 'hFFFF;
        if (d >= 32768) d -= 65536;
        m_prev = ph;
        m_amps.push_back(amp);
        m_dphs.push_back(d);
        if (m_amps.size() < 4) return 0;
        sa = 0; sd = 0; pk = 0;
        foreach (m_amps[i]) begin
            sa += m_amps[i];
            sd += m_dphs[i];
            if (m_amps[i] > pk) pk = m_amps[i];
        end
        m_avg_amp = 16'(sa / 4);
        q = sd / 4;
        if (sd < 0 && q * 4 != sd) q -= 1;
        m_avg_dph = 16'(q);
`ifdef AMP_PEAK_HOLD_EN
        m_peak = 16'(pk);
`endif
        m_amps.delete();
        m_dphs.delete();
        return 1;
    endfunction

    function automatic void mdl_clear();
        m_primed = 0;
        m_amps.delete();
        m_dphs.delete();
        m_peak = '0;
    endfunction

    function automatic void mdl_reset();
        mdl_clear();
        m_prev = 0;
        m_avg_amp = '0;
        m_avg_dph = '0;
    endfunction

    // ------------------------------------------------------ stimulus helpers
    task automatic send(input int amp, input int ph, output bit ev);
        in_amp = 16'(amp);
        in_ph = 16'(ph);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ev = mdl_sample(amp, ph);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        mdl_clear();
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        #12;
        n_checks++;
        if ({avg_valid, avg_amp, avg_dph, pk_obs} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_hold: valid=%b amp=%0d dph=%0d pk=%0d expected all 0",
                     avg_valid, avg_amp, avg_dph, pk_obs);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        mdl_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({avg_valid, avg_amp, avg_dph, pk_obs} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b amp=%0d dph=%0d expected all 0",
                     avg_valid, avg_amp, avg_dph);
        end
    endtask

    task automatic test_const();
        bit ev;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            send(1000, 0, ev);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL const[%0d]: got v=%b amp=%0d dph=%0d pk=%0d, want v=%b amp=%0d dph=%0d pk=%0d",
                         i, avg_valid, avg_amp, avg_dph, pk_obs, ev, m_avg_amp, m_avg_dph, m_peak);
            end
        end
        n_checks++;
        if (avg_valid !== 1'b1 || avg_amp !== 16'd1000 || avg_dph !== 16'd0) begin
            n_fail++;
            $display("FAIL const_value: got v=%b amp=%0d dph=%0d, want v=1 amp=1000 dph=0",
                     avg_valid, avg_amp, avg_dph);
        end
        @(posedge clk); #1;
        n_checks++;
        if (avg_valid !== 1'b0 || avg_amp !== 16'd1000) begin
            n_fail++;
            $display("FAIL const_one_cycle: got v=%b amp=%0d, want v=0 amp=1000", avg_valid, avg_amp);
        end
    endtask

    task automatic test_ramp(input int gap);
        int amps[5] = '{7, 10, 50, 30, 20};
        bit ev;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            send(amps[i], i * 100, ev);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL ramp_gap%0d[%0d]: got v=%b amp=%0d dph=%0d pk=%0d, want v=%b amp=%0d dph=%0d pk=%0d",
                         gap, i, avg_valid, avg_amp, avg_dph, pk_obs, ev, m_avg_amp, m_avg_dph, m_peak);
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                n_checks++;
                if (avg_valid !== 1'b0 || avg_amp !== m_avg_amp || avg_dph !== m_avg_dph) begin
                    n_fail++;
                    $display("FAIL ramp_gap%0d_idle: got v=%b amp=%0d dph=%0d, want v=0 amp=%0d dph=%0d",
                             gap, avg_valid, avg_amp, avg_dph, m_avg_amp, m_avg_dph);
                end
            end
        end
        n_checks++;
        if (avg_amp !== 16'd27 || avg_dph !== 16'd100) begin
            n_fail++;
            $display("FAIL ramp_gap%0d_value: got amp=%0d dph=%0d, want amp=27 dph=100", gap, avg_amp, avg_dph);
        end
`ifdef AMP_PEAK_HOLD_EN
        n_checks++;
        if (pk_obs !== 16'd50) begin
            n_fail++;
            $display("FAIL ramp_peak: got %0d want 50", pk_obs);
        end
`endif
    endtask

    task automatic test_wrap();
        int ph[5] = '{32600, 32700, -32736, -32636, -32536};
        bit ev;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            send(300 + i, ph[i], ev);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%b amp=%0d dph=%0d, want v=%b amp=%0d dph=%0d",
                         i, avg_valid, avg_amp, avg_dph, ev, m_avg_amp, m_avg_dph);
            end
        end
        n_checks++;
        if (avg_dph !== 16'd100) begin
            n_fail++;
            $display("FAIL wrap_value: got dph=%0d want 100", avg_dph);
        end
        // Descending phase, continuing from the last phase without re-prime.
        for (int i = 1; i <= 4; i++) begin
            send(5, -32536 - 3 * i, ev);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph} !== {ev, m_avg_amp, m_avg_dph}) begin
                n_fail++;
                $display("FAIL desc[%0d]: got v=%b amp=%0d dph=%0d, want v=%b amp=%0d dph=%0d",
                         i, avg_valid, avg_amp, avg_dph, ev, m_avg_amp, m_avg_dph);
            end
        end
        n_checks++;
        if (avg_valid !== 1'b1 || $signed(avg_dph) !== -16'sd3) begin
            n_fail++;
            $display("FAIL desc_value: got v=%b dph=%0d want v=1 dph=-3", avg_valid, $signed(avg_dph));
        end
    endtask

    task automatic test_back_to_back();
        int strobes[$];
        bit ev;
        do_clear();
        send(1, 40000, ev);
        for (int i = 0; i < 12; i++) begin
            send($urandom_range(0, 65535), $urandom_range(0, 65535), ev);
            if (avg_valid === 1'b1) strobes.push_back(i);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%b amp=%0d dph=%0d pk=%0d, want v=%b amp=%0d dph=%0d pk=%0d",
                         i, avg_valid, avg_amp, avg_dph, pk_obs, ev, m_avg_amp, m_avg_dph, m_peak);
            end
        end
        n_checks++;
        if (strobes.size() != 3 || strobes[0] != 3 || strobes[1] != 7 || strobes[2] != 11) begin
            n_fail++;
            $display("FAIL b2b_strobes: got %0d strobes, want 3 at samples 3,7,11", strobes.size());
        end
    endtask

    task automatic test_clear();
        bit ev;
        do_clear();
        send(9, 0, ev);
        send(100, 10, ev);
        send(200, 20, ev);
        do_clear();
        n_checks++;
        if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {1'b0, m_avg_amp, m_avg_dph, m_peak}) begin
            n_fail++;
            $display("FAIL clear_mid: got v=%b amp=%0d dph=%0d pk=%0d, want v=0 amp=%0d dph=%0d pk=%0d",
                     avg_valid, avg_amp, avg_dph, pk_obs, m_avg_amp, m_avg_dph, m_peak);
        end
        for (int i = 0; i < 5; i++) begin
            send(400 + 8 * i, 1000 - 7 * i, ev);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL clear_reprime[%0d]: got v=%b amp=%0d dph=%0d, want v=%b amp=%0d dph=%0d",
                         i, avg_valid, avg_amp, avg_dph, ev, m_avg_amp, m_avg_dph);
            end
        end
        // Three samples of a new block, then the 4th arrives together with clear.
        for (int i = 0; i < 3; i++) send(60000, 2000 + 50 * i, ev);
        in_amp = 16'd60000;
        in_ph = 16'd2150;
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear = 1'b0;
        mdl_clear();
        n_checks++;
        if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {1'b0, m_avg_amp, m_avg_dph, m_peak}) begin
            n_fail++;
            $display("FAIL clear_on_last: got v=%b amp=%0d dph=%0d, want v=0 amp=%0d dph=%0d",
                     avg_valid, avg_amp, avg_dph, m_avg_amp, m_avg_dph);
        end
        @(posedge clk); #1;
        n_checks++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_on_last_late: got v=%b want 0", avg_valid);
        end
    endtask

    task automatic test_async_reset();
        bit ev;
        do_clear();
        for (int i = 0; i < 5; i++) send(500 + i, 300 * i, ev);
        n_checks++;
        if ({avg_valid, avg_amp, avg_dph} !== {1'b1, m_avg_amp, m_avg_dph}) begin
            n_fail++;
            $display("FAIL areset_pre: got v=%b amp=%0d dph=%0d, want v=1 amp=%0d dph=%0d",
                     avg_valid, avg_amp, avg_dph, m_avg_amp, m_avg_dph);
        end
        send(700, 1600, ev);
        send(700, 1700, ev);
        #3 reset = 1'b0;
        #1;
        mdl_reset();
        n_checks++;
        if ({avg_valid, avg_amp, avg_dph, pk_obs} !== 49'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got v=%b amp=%0d dph=%0d pk=%0d, want all 0",
                     avg_valid, avg_amp, avg_dph, pk_obs);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1200 - 100 * i, 5000 + 64 * i, ev);
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL areset_after[%0d]: got v=%b amp=%0d dph=%0d, want v=%b amp=%0d dph=%0d",
                         i, avg_valid, avg_amp, avg_dph, ev, m_avg_amp, m_avg_dph);
            end
        end
    endtask

    task automatic test_random();
        bit ev;
        int r;
        do_clear();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            ev = 0;
            if (r == 0) begin
                do_clear();
            end else if (r < 7) begin
                @(posedge clk); #1;
            end else begin
                send($urandom_range(0, 65535), $urandom_range(0, 65535), ev);
            end
            n_checks++;
            if ({avg_valid, avg_amp, avg_dph, pk_obs} !== {ev, m_avg_amp, m_avg_dph, m_peak}) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b amp=%0d dph=%0d pk=%0d, want v=%b amp=%0d dph=%0d pk=%0d",
                         i, avg_valid, avg_amp, avg_dph, pk_obs, ev, m_avg_amp, m_avg_dph, m_peak);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_ramp(0);
        test_ramp(2);
        test_wrap();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amp_ph_averager.md
AMP_PH_AVERAGER -- requirements
Module: amp_ph_averager

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, unsigned amplitude width.
REQ-002 SHALL have parameter PH_WIDTH, default 16, two's-complement phase width; full scale wraps mod 2^PH_WIDTH.
REQ-003 SHALL have parameter LOG2_LEN, default 2, block length N = 2^LOG2_LEN; legal range 1..8.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous restart of averaging; re-prime phase.
REQ-007 in_amp  input  DATA_WIDTH  amplitude from the upstream amplitude/phase detector output.
REQ-008 in_ph  input  PH_WIDTH  phase from the upstream amplitude/phase detector output.
REQ-009 in_valid  input  1  in_amp/in_ph qualifier, driven by the detector's data-valid output.
REQ-010 avg_amp  output  DATA_WIDTH  block mean amplitude.
REQ-011 avg_dph  output  PH_WIDTH  block mean phase increment per sample (frequency estimate).
REQ-012 avg_valid  output  1  one-cycle strobe qualifying avg_amp/avg_dph.

Function
REQ-013 SHALL have two states: PRIME (no previous phase held) and ACCUM.
REQ-014 In PRIME, on in_valid: SHALL store in_ph as prev_ph, discard the sample, clear count and sums, and go to ACCUM.
REQ-015 In ACCUM, on in_valid: SHALL add in_amp to amp_sum (DATA_WIDTH+LOG2_LEN bits, no overflow possible).
REQ-016 In ACCUM, on in_valid: SHALL compute dph = in_ph - prev_ph mod 2^PH_WIDTH, interpreted as signed, sign-extend, add to dph_sum (PH_WIDTH+LOG2_LEN bits), set prev_ph = in_ph, and increment count.
REQ-017 When the Nth valid sample of a block is accepted, the next cycle SHALL present avg_amp = amp_sum>>LOG2_LEN (floor), avg_dph = dph_sum>>>LOG2_LEN (arithmetic, floor toward -inf), and avg_valid=1 for exactly one cycle.
REQ-018 The next block SHALL start on the sample following the Nth with zeroed sums, stay in ACCUM, and keep prev_ph (no re-prime); back-to-back valid input SHALL lose no samples.
REQ-019 Cycles with in_valid=0 SHALL change no state; gaps of any length SHALL be tolerated.
REQ-020 avg_amp/avg_dph SHALL hold their last values between strobes.
REQ-021 clear=1 SHALL go to PRIME, zero count and sums, and suppress any avg_valid pending for that edge; clear has priority over a simultaneous in_valid, and that sample is dropped.
REQ-022 All outputs SHALL be registered; latency from the Nth accepted sample to avg_valid is 1 clock.

Reset
REQ-023 reset low SHALL immediately force state=PRIME, count=0, sums=0, prev_ph=0, avg_amp=0, avg_dph=0, avg_valid=0, regardless of clk.
REQ-024 Reset release SHALL take effect on the first rising clk edge with reset high; a partial block interrupted by reset SHALL never produce avg_valid.

Configuration
REQ-025 Macro AMP_PEAK_HOLD_EN defined: SHALL add output peak_amp (DATA_WIDTH) = maximum in_amp of the block, updated together with avg_valid, reset to 0, cleared by clear.
REQ-026 Macro AMP_PEAK_HOLD_EN undefined: peak_amp port and its logic SHALL be absent; all other behaviour is identical.

Verification (LOG2_LEN=2, N=4, widths 16)
REQ-027 Prime sample, then 4 samples amp=1000, ph=0 -> avg_amp=1000, avg_dph=0, avg_valid high one cycle after the 4th sample.
REQ-028 ph 0,100,200,300,400 with amps 10,50,30,20 -> avg_dph=100, avg_amp=27; with AMP_PEAK_HOLD_EN, peak_amp=50.
REQ-029 Wrap: ph 32600,32700,-32736,-32636,-32536 -> avg_dph=100; ph descending by 3 per sample -> avg_dph=-3.
REQ-030 Same stimulus with in_valid asserted every third cycle -> identical results, avg_valid one cycle after the 4th valid; 12 back-to-back samples -> three strobes, 4 cycles apart.
REQ-031 clear after 2 samples of a block -> no avg_valid; a new prime plus 4 samples gives correct means; clear coincident with the 4th sample -> no strobe.
REQ-032 reset driven low between clock edges mid-block -> all outputs 0 at once; after release, the first valid sample primes and the following 4 produce a correct strobe.
